uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter. Successor to the fixed-rate, single-byte transmitter.
Adds a runtime baud divisor, selectable parity (none/even/odd), 1 or 2 stop bits, and an internal transmit FIFO with a valid/ready write interface.
Sits between the CPU peripheral bus and the TXD pin; frames go out back-to-back while the FIFO holds data.

Parameters:
PAYLOAD_BITS, 8, data bits per frame; legal 5..9.
FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2.
DIV_WIDTH, 16, width of cfg_div.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
uart_txd  output  1  serial output, idle high, registered
tx_valid  input  1  write request
tx_ready  output  1  FIFO can accept; high when FIFO not full
tx_data  input  PAYLOAD_BITS  data to enqueue
cfg_div  input  DIV_WIDTH  bit period minus one, in clk cycles
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  1 = two stop bits, 0 = one
fifo_level  output  $clog2(FIFO_DEPTH+1)  entries currently queued, excluding the frame in flight
busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync-safe deassert):
  - uart_txd=1, tx_ready=1, fifo_level=0, busy=0.
  - FSM to IDLE, FIFO emptied, shift register and counters cleared.
  - Reset asserted mid-frame: txd returns high immediately; the partial frame is abandoned and queued data is lost.
- Write: an entry is accepted on a rising edge with tx_valid && tx_ready. tx_ready = (fifo_level != FIFO_DEPTH), derived from registered count.
- Full FIFO, pop in the same cycle: the write is still refused. No write-through on full.
- Empty FIFO: write and pop never occur in the same cycle; the entry must land first.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, latch cfg_div/cfg_parity/cfg_stop2, go to START.
  - Config changes after the pop do not affect the frame in flight.
  - START: txd=0 for one bit period.
  - DATA: PAYLOAD_BITS bits, LSB first, one bit period each.
  - PARITY: entered only if latched parity is 01 or 10.
    - Even: bit = XOR of all data bits.
    - Odd: bit = inverted XOR.
  - STOP: txd=1 for 1 or 2 bit periods.
  - End of last stop period:
    - FIFO non-empty: pop and enter START directly, so the next start bit follows the last stop bit with no idle cycle.
    - Otherwise go to IDLE.
- Bit period = latched cfg_div + 1 clk cycles. cfg_div=0 is legal (1 cycle/bit).
- The cycle counter resets at each bit boundary; no drift across bits.
- Latency: a write accepted at edge N into an empty, idle block pops at edge N+1; uart_txd goes low at edge N+2.
- Frame length in cycles = (cfg_div+1) x (1 + PAYLOAD_BITS + P + S), where P is 0 or 1 and S is 1 or 2.
- txd is always driven from a flop; there are no combinational paths from inputs to uart_txd.
- fifo_level increments on an accepted write and decrements on a pop; it is unchanged when both happen in the same cycle.
- Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, cfg_div=3, parity=00, stop2=0, write 0x55 -> txd low 2 edges after accept; sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (40 cycles); busy falls after the stop bit; txd stays high.
- cfg_div=1, parity=01, write 0x07 -> parity bit 1; repeat with parity=10 -> parity bit 0; cfg_stop2=1 -> stop high for 4 cycles, frame = 24 cycles.
- tx_valid held high with data 0x01..0x06, cfg_div=0:
  - 0x01 pops, then 4 more are accepted and tx_ready drops with fifo_level=4.
  - 0x06 is accepted only after the next pop.
  - All 6 frames go out back-to-back, each start bit immediately after the previous stop bit, in order.
- Write at full with a simultaneous pop -> write refused (data not enqueued); the next cycle tx_ready=1 and the write is accepted; fifo_level never exceeds 4.
- Mid-frame, change cfg_div 3->7 and cfg_parity 00->01 -> the current frame keeps 4-cycle bits and no parity; the next frame uses 8-cycle bits plus a parity bit.
- Assert resetn low during DATA bit 3 with 2 entries queued -> txd=1 immediately; after release: fifo_level=0, busy=0, no further frames, tx_ready=1.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Write-side handshake between a bus master (CPU peripheral bridge) and the
// UART transmitter FIFO.
//   tx_valid : master -> slave, write request
//   tx_data  : master -> slave, payload to enqueue
//   tx_ready : slave -> master, FIFO can accept this cycle
// An entry transfers on a rising clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8
) ();

  logic                    tx_valid;
  logic                    tx_ready;
  logic [PAYLOAD_BITS-1:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with runtime baud divisor, parity (none/even/odd), one or
// two stop bits and an internal transmit FIFO. Frames leave back-to-back for
// as long as the FIFO holds data.
//
// Ports:
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   wr         : write handshake (tx_valid / tx_ready / tx_data), slave side
//   cfg_div    : bit period minus one, in clk cycles (latched per frame)
//   cfg_parity : 00 none, 01 even, 10 odd, 11 none (latched per frame)
//   cfg_stop2  : 1 = two stop bits, 0 = one (latched per frame)
//   uart_txd   : serial output, idle high, driven straight from a flop
//   fifo_level : entries queued, excluding the frame in flight
//   busy       : FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  uart_tx_fifo_if.slave                      wr,
  input  logic [DIV_WIDTH-1:0]               cfg_div,
  input  logic [1:0]                         cfg_parity,
  input  logic                               cfg_stop2,
  output logic                               uart_txd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(PAYLOAD_BITS);

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(PAYLOAD_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        count;
  logic                    push, pop;
  logic [PAYLOAD_BITS-1:0] head;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a full FIFO to a write-through.
  assign wr.tx_ready = (count != LVL_FULL);
  assign push        = wr.tx_valid && wr.tx_ready;
  assign head        = mem[rd_ptr];
  assign fifo_level  = count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.tx_data;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [2:0]              state;
  logic [DIV_WIDTH-1:0]    baud_cnt;
  logic [DIV_WIDTH-1:0]    div_lat;
  logic [IDX_W-1:0]        bit_idx;
  logic [PAYLOAD_BITS-1:0] shift;
  logic                    par_en_lat;
  logic                    par_bit_lat;
  logic                    stop2_lat;
  logic                    bit_done;
  logic                    last_stop;
  logic                    frame_end;
  logic                    txd_next;

  assign bit_done  = (baud_cnt == div_lat);
  assign last_stop = (bit_idx == (stop2_lat ? IDX_W'(1) : IDX_W'(0)));
  assign frame_end = (state == S_STOP) && bit_done && last_stop;

  // A pop from IDLE or at the very end of the last stop bit; the latter chains
  // the next start bit onto the stop bit with no idle cycle in between.
  assign pop  = (count != '0) && ((state == S_IDLE) || frame_end);
  assign busy = (state != S_IDLE) || (count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      div_lat     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_en_lat  <= 1'b0;
      par_bit_lat <= 1'b0;
      stop2_lat   <= 1'b0;
    end else if (pop) begin
      // Configuration is captured here and held for the whole frame.
      state       <= S_START;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= head;
      div_lat     <= cfg_div;
      par_en_lat  <= ^cfg_parity;
      par_bit_lat <= (^head) ^ (cfg_parity == 2'b10);
      stop2_lat   <= cfg_stop2;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
        end
        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= par_en_lat ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (last_stop) begin
              state <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Line level for the current state, registered one cycle later so the pin
  // always comes from a flop.
  // NOTE: txd_next gets a default before the case so no latch is inferred.
  always_comb begin
    txd_next = 1'b1;
    case (state)
      S_START:  txd_next = 1'b0;
      S_DATA:   txd_next = shift[0];
      S_PARITY: txd_next = par_bit_lat;
      default:  txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) uart_txd <= 1'b1;
    else         uart_txd <= txd_next;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed, self-checking bench for uart_tx_fifo (PAYLOAD_BITS=8,
// FIFO_DEPTH=4, DIV_WIDTH=16). Single-frame vectors come from a table of
// hand-computed line patterns; back-to-back traffic, full-FIFO refusal,
// mid-frame configuration change and mid-frame reset are written out as
// sequences. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        uart_txd;
  logic [2:0]  fifo_level;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.PAYLOAD_BITS(8)) wr_if ();

  uart_tx_fifo #(
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH  (4),
    .DIV_WIDTH   (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (wr_if),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .uart_txd   (uart_txd),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  // One record per single-frame vector. bits holds the line level per bit
  // time, bit 0 first on the wire (start bit), as worked out by hand.
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
    logic [15:0] bits;
    int          nbits;
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stretch a per-bit pattern into a per-cycle pattern.
  function automatic logic [127:0] expand(input logic [15:0] bits,
                                          input int nbits, input int period);
    logic [127:0] v = '0;
    for (int i = 0; i < nbits * period; i++) v[i] = bits[i / period];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] got_b;
    logic         busy_mid;
    logic         rdy, vld;
    logic         ok;
    logic [7:0]   d;
    logic [9:0]   exp10;
    int           nd;
    int           acc[8];
    int           max_lvl;

    //                data    div    par    stop   bits      n   len
    vecs[0] = '{8'h55, 16'd3, 2'b00, 1'b0, 16'h02AA, 10, 40};
    vecs[1] = '{8'h07, 16'd1, 2'b01, 1'b0, 16'h060E, 11, 22};
    vecs[2] = '{8'h07, 16'd1, 2'b10, 1'b0, 16'h040E, 11, 22};
    vecs[3] = '{8'h07, 16'd1, 2'b10, 1'b1, 16'h0C0E, 12, 24};
    vecs[4] = '{8'hA3, 16'd0, 2'b11, 1'b1, 16'h0746, 11, 11};
    vecs[5] = '{8'h80, 16'd2, 2'b10, 1'b0, 16'h0500, 11, 33};

    wr_if.tx_valid = 1'b0;
    wr_if.tx_data  = 8'h00;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_txd",   128'(uart_txd),       128'(1));
    check("rst_ready", 128'(wr_if.tx_ready), 128'(1));
    check("rst_level", 128'(fifo_level),     128'(0));
    check("rst_busy",  128'(busy),           128'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // ---------------- single-frame vectors ----------------
    for (int i = 0; i < 6; i++) begin
      cfg_div        = vecs[i].div;
      cfg_parity     = vecs[i].par;
      cfg_stop2      = vecs[i].stop2;
      wr_if.tx_data  = vecs[i].data;
      wr_if.tx_valid = 1'b1;
      check($sformatf("v%0d_ready", i), 128'(wr_if.tx_ready), 128'(1));
      tick();                                   // edge N: accepted
      wr_if.tx_valid = 1'b0;
      check($sformatf("v%0d_level_n", i), 128'(fifo_level), 128'(1));
      tick();                                   // edge N+1: popped
      check($sformatf("v%0d_level_n1", i), 128'(fifo_level), 128'(0));
      check($sformatf("v%0d_txd_n1", i),   128'(uart_txd),   128'(1));
      got      = '0;
      busy_mid = 1'b0;
      for (int k = 0; k < vecs[i].len; k++) begin
        tick();                                 // edges N+2 ...
        got[k] = uart_txd;
        if (k == vecs[i].len / 2) busy_mid = busy;
      end
      check($sformatf("v%0d_frame", i), got,
            expand(vecs[i].bits, vecs[i].nbits, 32'(vecs[i].div) + 1));
      check($sformatf("v%0d_busy_mid", i), 128'(busy_mid), 128'(1));
      check($sformatf("v%0d_busy_end", i), 128'(busy),     128'(0));
      tick();
      check($sformatf("v%0d_idle_txd", i), 128'(uart_txd), 128'(1));
    end

    // ---------------- back-to-back, full FIFO, refused write ----------------
    cfg_div    = 16'd0;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    nd      = 1;
    max_lvl = 0;
    got_b   = '0;
    for (int j = 0; j < 8; j++) acc[j] = -1;
    for (int c = 0; c < 66; c++) begin
      wr_if.tx_valid = (nd <= 6);
      wr_if.tx_data  = 8'(nd);
      rdy = wr_if.tx_ready;
      vld = wr_if.tx_valid;
      tick();                                   // edge c
      got_b[c] = uart_txd;
      if (vld && rdy) begin
        acc[nd] = c;
        nd++;
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (c == 4) begin
        check("b2b_level_full", 128'(fifo_level),     128'(4));
        check("b2b_ready_full", 128'(wr_if.tx_ready), 128'(0));
      end
      if (c == 11) begin
        check("b2b_refused_level", 128'(fifo_level),     128'(3));
        check("b2b_ready_reopen",  128'(wr_if.tx_ready), 128'(1));
      end
      if (c == 12) check("b2b_level_refill", 128'(fifo_level), 128'(4));
    end
    wr_if.tx_valid = 1'b0;
    check("b2b_acc_02",  128'(acc[2]),  128'(1));
    check("b2b_acc_05",  128'(acc[5]),  128'(4));
    check("b2b_acc_06",  128'(acc[6]),  128'(12));
    check("b2b_max_lvl", 128'(max_lvl), 128'(4));
    for (int f = 0; f < 6; f++) begin
      d     = 8'(f + 1);
      exp10 = {1'b1, d, 1'b0};
      check($sformatf("b2b_frame%0d", f), 128'(got_b[2 + 10 * f +: 10]),
            128'(exp10));
    end
    check("b2b_idle_txd", 128'(got_b[65:62]), 128'(4'hF));
    check("b2b_busy_end", 128'(busy),         128'(0));

    // ---------------- config change mid-frame ----------------
    cfg_div        = 16'd3;
    cfg_parity     = 2'b00;
    cfg_stop2      = 1'b0;
    wr_if.tx_data  = 8'hA5;
    wr_if.tx_valid = 1'b1;
    tick();                                     // E0: A5 accepted
    wr_if.tx_data  = 8'h3C;
    tick();                                     // E1: A5 popped, 3C accepted
    wr_if.tx_valid = 1'b0;
    got = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == 8) begin
        cfg_div    = 16'd7;
        cfg_parity = 2'b01;
      end
      tick();
      got[k] = uart_txd;
    end
    check("cfg_frame_old", got, expand(16'h034A, 10, 4));
    got = '0;
    for (int k = 0; k < 88; k++) begin
      tick();
      got[k] = uart_txd;
    end
    check("cfg_frame_new", got, expand(16'h0478, 11, 8));
    check("cfg_busy_end",  128'(busy), 128'(0));

    // ---------------- reset mid-frame ----------------
    cfg_div        = 16'd3;
    cfg_parity     = 2'b00;
    cfg_stop2      = 1'b0;
    wr_if.tx_valid = 1'b1;
    wr_if.tx_data  = 8'h00;
    tick();                                     // E0
    wr_if.tx_data  = 8'h11;
    tick();                                     // E1: 00 popped
    wr_if.tx_data  = 8'h22;
    tick();                                     // E2
    wr_if.tx_valid = 1'b0;
    for (int k = 0; k < 16; k++) tick();        // E18: data bit 3 starts
    check("rst_mid_txd_pre",   128'(uart_txd),   128'(0));
    check("rst_mid_level_pre", 128'(fifo_level), 128'(2));
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_txd",   128'(uart_txd),       128'(1));
    check("rst_mid_level", 128'(fifo_level),     128'(0));
    check("rst_mid_busy",  128'(busy),           128'(0));
    check("rst_mid_ready", 128'(wr_if.tx_ready), 128'(1));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) ok = 1'b0;
    end
    check("rst_after_quiet", 128'(ok),             128'(1));
    check("rst_after_ready", 128'(wr_if.tx_ready), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
